instr_fetch: RTL and testbench

Fetch stage of the RV32I core, directly upstream of the instruction memory and of decode. It owns the program counter, drives the combinational instruction-memory read address, and registers each returned word together with its PC into a valid/ready output stage consumed by decode. It supports back-pressure stalls, redirects from branch/jump resolution, and a fault state for misaligned redirect targets.

---
 rtl/instr_fetch.sv | 148 ++++++++++++++
 tb/tb_instr_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory
// address, and registers each fetched word with its PC into a valid/ready
// output stage. Handles back-pressure, redirects and misaligned-target faults.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;

    logic        accept;
    logic        slot_free;
    logic        redirect_aligned;

    logic        pc_en;
    logic [31:0] pc_nxt;
    logic        capture;
    logic        load_fault;
    logic        clear_valid;

    assign imem_addr        = pc_q;
    assign accept           = out_valid && out_ready;
    assign slot_free        = !out_valid || out_ready;
    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a redirect from any state wins; IDLE always moves on.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = redirect_aligned ? RUN : FAULT;
        end else if (state == IDLE) begin
            state_nxt = RUN;
        end
    end

    // Per-cycle control: PC update and what the output register does.
    always_comb begin
        pc_en       = 1'b0;
        pc_nxt      = pc_q;
        capture     = 1'b0;
        load_fault  = 1'b0;
        clear_valid = 1'b0;
        if (redirect_valid) begin
            pc_en = 1'b1;
            if (redirect_aligned) begin
                // Kill whatever is in the output slot; the target beat
                // arrives one cycle later.
                pc_nxt      = redirect_pc;
                clear_valid = 1'b1;
            end else begin
                pc_nxt     = {redirect_pc[31:2], 2'b00};
                load_fault = 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (slot_free) begin
                        capture = 1'b1;
                        pc_en   = 1'b1;
                        pc_nxt  = pc_q + 32'd4;
                    end
                end
                FAULT: begin
                    // Once the fault beat is taken the stage stays empty.
                    if (accept) begin
                        clear_valid = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (pc_en) begin
            pc_q <= pc_nxt;
        end
    end

    // Output register: fault load, normal capture, or drop of the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pc    <= 32'h0;
            out_instr <= NOP_INSTR;
            out_fault <= 1'b0;
        end else if (load_fault) begin
            out_valid <= 1'b1;
            out_pc    <= redirect_pc;
            out_instr <= NOP_INSTR;
            out_fault <= 1'b1;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_pc    <= pc_q;
            out_instr <= imem_data;
            out_fault <= 1'b0;
        end else if (clear_valid) begin
            out_valid <= 1'b0;
        end
    end

    // Count of accepted beats, fault beats included; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'h0;
        end else if (accept) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: random ready/redirect stimulus with a
// transaction-level model of the expected beat stream and a scoreboard.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;

    beat_t exp_q[$];
    beat_t redir_q[$];

    instr_fetch #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_fault     (out_fault),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    assign imem_data = mem_word(imem_addr);

    function automatic beat_t norm_beat(input logic [31:0] a);
        beat_t b;
        b.pc    = a;
        b.instr = mem_word(a);
        b.fault = 1'b0;
        return b;
    endfunction

    function automatic beat_t fault_beat(input logic [31:0] a);
        beat_t b;
        b.pc    = a;
        b.instr = NOP;
        b.fault = 1'b1;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, driven just after the rising edge.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv) begin
            if (rpc[1:0] == 2'b00) redir_q.push_back(norm_beat(rpc));
            else                   redir_q.push_back(fault_beat(rpc));
        end
    endtask

    task automatic rand_step();
        logic [31:0] t;
        logic        rdy;
        logic        rv;
        rdy = ($urandom_range(0, 9) < 7);
        rv  = ($urandom_range(0, 15) == 0);
        t   = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        if ($urandom_range(0, 7) == 0) t[31:4] = '1;
        if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
        step(rdy, rv, t);
    endtask

    // Asynchronous reset mid-cycle, then release and check first-beat timing.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_fetch_count", fetch_count, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, NOP);
        check1("rst_out_fault", out_fault, 1'b0);
        exp_q.delete();
        redir_q.delete();
        exp_q.push_back(norm_beat(RST_PC));
        acc_cnt        = 0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("idle_cycle_no_beat", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check1("first_beat_valid", out_valid, 1'b1);
        check("first_beat_pc", out_pc, RST_PC);
    endtask

    // Monitor / scoreboard: samples on the falling edge.
    initial begin
        logic        p_valid, p_ready, p_redir, p_al, pp_al, p_acc_norm, p_fault;
        logic [31:0] p_rpc, p_pc, p_instr, p_addr;
        beat_t       e;
        p_valid = 0; p_ready = 0; p_redir = 0; p_al = 0; pp_al = 0; p_acc_norm = 0;
        p_fault = 0; p_rpc = 0; p_pc = 0; p_instr = 0; p_addr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_valid = 0; p_redir = 0; p_al = 0; pp_al = 0; p_acc_norm = 0;
            end else begin
                if (p_valid && !p_ready && !p_redir) begin
                    check1("stall_hold_valid", out_valid, 1'b1);
                    check("stall_hold_pc", out_pc, p_pc);
                    check("stall_hold_instr", out_instr, p_instr);
                    check1("stall_hold_fault", out_fault, p_fault);
                    check("stall_hold_addr", imem_addr, p_addr);
                end
                if (p_redir && p_al) begin
                    check1("redirect_bubble", out_valid, 1'b0);
                    check("redirect_addr", imem_addr, p_rpc);
                end
                if (p_redir && !p_al) begin
                    check1("fault_beat_valid", out_valid, 1'b1);
                    check1("fault_beat_flag", out_fault, 1'b1);
                    check("fault_addr", imem_addr, {p_rpc[31:2], 2'b00});
                end
                if (pp_al && !p_redir) check1("redirect_target_n2", out_valid, 1'b1);
                if (p_acc_norm && !p_redir) check1("throughput", out_valid, 1'b1);
                check("fetch_count", fetch_count, 32'(acc_cnt));

                p_acc_norm = 1'b0;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check1("unexpected_beat", out_valid, 1'b0);
                    end else begin
                        e = exp_q[0];
                        check("beat_pc", out_pc, e.pc);
                        check("beat_instr", out_instr, e.instr);
                        check1("beat_fault", out_fault, e.fault);
                        if (out_ready) begin
                            acc_cnt++;
                            void'(exp_q.pop_front());
                            if (!e.fault) begin
                                exp_q.push_back(norm_beat(e.pc + 32'd4));
                                p_acc_norm = 1'b1;
                            end
                        end
                    end
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    if (redir_q.size() == 0) check1("redirect_queue", 1'b0, 1'b1);
                    else exp_q.push_back(redir_q.pop_front());
                end

                pp_al   = p_redir && p_al;
                p_redir = redirect_valid;
                p_al    = (redirect_pc[1:0] == 2'b00);
                p_rpc   = redirect_pc;
                p_valid = out_valid;
                p_ready = out_ready;
                p_pc    = out_pc;
                p_instr = out_instr;
                p_fault = out_fault;
                p_addr  = imem_addr;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        do_reset();
        // Straight-line fetch across the address wrap.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        // Three-cycle stall, then resume.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        // Redirect while a beat is handshaked.
        step(1'b1, 1'b1, 32'h100);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
        // Redirect while a beat is stalled.
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h40);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
        // Misaligned redirect, idle fault state, recovery.
        step(1'b1, 1'b1, 32'h42);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h80);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
        // Fault beat held under back-pressure.
        step(1'b0, 1'b1, 32'h1003);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        // Random traffic.
        for (int i = 0; i < 400; i++) rand_step();
        // Mid-stream reset and more traffic.
        do_reset();
        for (int i = 0; i < 60; i++) rand_step();
        step(1'b1, 1'b1, 32'h300);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check1("enough_beats", (acc_cnt >= 10), 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
